// File: rtl/param_mem_init.sv
// param_mem_init
//   Simple dual-port RAM (one synchronous write port, one registered read
//   port) with a hardware clear sequencer. After reset, or when clr is
//   requested, the sequencer writes INIT_VALUE to every word, one word per
//   clock. User reads and writes are accepted only once the sweep finishes
//   (init_done=1). A read and a write to the same address in the same cycle
//   return the newly written data (write-first).
//
//   Optional feature macro: MEM_PARITY_EN
//     defined   : each word carries an even-parity bit; inj_par flips it on a
//                 user write; parity_err flags a mismatch on the read data.
//     undefined : no parity storage, inj_par unused, parity_err tied to 0.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH
//   INIT_VALUE  value written by the clear sweep (truncated to DATA_WIDTH)
//
// Ports
//   clk            clock, all logic on rising edge
//   rst            synchronous active-high reset
//   clr            request a clear sweep
//   we             write enable
//   write_address  write address
//   data_in        write data
//   inj_par        invert stored parity bit on this write (parity build only)
//   re             read enable
//   read_address   read address
//   data_out       registered read data
//   rd_valid       data_out holds the result of the previous-edge read
//   init_done      1 when the sweep is complete and ports are live
//   parity_err     parity mismatch on current data_out
module param_mem_init #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int INIT_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  inj_par,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_done,
  output logic                  parity_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   init_ptr_reg;
  logic [WORD_W-1:0]       mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [WORD_W-1:0]       mem_wword;
  logic [WORD_W-1:0]       user_word;
  logic                    user_wr;
  logic [WORD_W-1:0]       read_word;

  // Stored word for a user write: data plus (optionally) its parity bit.
`ifdef MEM_PARITY_EN
  assign user_word = {(^data_in) ^ inj_par, data_in};
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
  assign user_word      = data_in;
`endif

  // clr in READY drops any same-cycle user access.
  assign user_wr = (state_reg == ST_READY) && we && !clr;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_address;
    mem_wword = user_word;
    if (!rst) begin
      if (state_reg == ST_INIT) begin
        // Sweep writes continue even on a clr edge; the sweep restarts anyway.
        mem_we    = 1'b1;
        mem_waddr = init_ptr_reg;
`ifdef MEM_PARITY_EN
        mem_wword = {^INIT_WORD, INIT_WORD};
`else
        mem_wword = INIT_WORD;
`endif
      end else begin
        mem_we = user_wr;
      end
    end
  end

  // Storage array: no reset, single write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // Write-first bypass for a same-address read in the same cycle.
  assign read_word = (user_wr && (write_address == read_address)) ? user_word
                                                                  : mem[read_address];

`ifndef MEM_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_ptr_reg <= '0;
      init_done    <= 1'b0;
      data_out     <= '0;
      rd_valid     <= 1'b0;
`ifdef MEM_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_INIT: begin
          rd_valid <= 1'b0;
`ifdef MEM_PARITY_EN
          parity_err <= 1'b0;
`endif
          if (clr) begin
            init_ptr_reg <= '0;
          end else if (init_ptr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
            init_ptr_reg <= '0;
            state_reg    <= ST_READY;
            init_done    <= 1'b1;
          end else begin
            init_ptr_reg <= init_ptr_reg + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            state_reg    <= ST_INIT;
            init_ptr_reg <= '0;
            init_done    <= 1'b0;
            rd_valid     <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_err   <= 1'b0;
`endif
          end else if (re) begin
            data_out <= read_word[DATA_WIDTH-1:0];
            rd_valid <= 1'b1;
`ifdef MEM_PARITY_EN
            parity_err <= (^read_word[DATA_WIDTH-1:0]) != read_word[DATA_WIDTH];
`endif
          end else begin
            rd_valid <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_mem_init.sv
// Testbench for param_mem_init (default parameters: 8-bit data, 16 words,
// INIT_VALUE 0). Directed table vectors, hand-written sweep sequences and a
// randomized phase checked against a behavioural memory model.
module tb_param_mem_init;

`ifdef MEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, clr, we, inj_par, re;
  logic [3:0] write_address, read_address;
  logic [7:0] data_in, data_out;
  logic       rd_valid, init_done, parity_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_mem_init #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .INIT_VALUE(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .write_address(write_address),
    .data_in(data_in), .inj_par(inj_par), .re(re), .read_address(read_address),
    .data_out(data_out), .rd_valid(rd_valid), .init_done(init_done),
    .parity_err(parity_err)
  );

  // ---------------- behavioural model ----------------
  // A sweep is "clear everything, then stay deaf for DEPTH edges".
  logic [7:0] m_data [DEPTH];
  logic       m_par  [DEPTH];
  int         m_busy;          // sweep edges still to go
  logic [7:0] m_do;
  logic       m_rv, m_done, m_perr;

  task automatic model_step(input logic r, c, w, input logic [3:0] wa,
                            input logic [7:0] d, input logic inj,
                            input logic rd, input logic [3:0] ra);
    if (r || c) begin
      m_busy = DEPTH;
      m_done = 1'b0;
      m_rv   = 1'b0;
      m_perr = 1'b0;
      if (r) m_do = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        m_data[i] = 8'h00;
        m_par[i]  = 1'b0;
      end
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      m_rv   = 1'b0;
      m_perr = 1'b0;
      if (m_busy == 0) m_done = 1'b1;
    end else begin
      if (w) begin
        m_data[wa] = d;
        m_par[wa]  = (^d) ^ inj;
      end
      if (rd) begin
        m_do   = m_data[ra];
        m_rv   = 1'b1;
        m_perr = PAR_EN && ((^m_data[ra]) != m_par[ra]);
      end else begin
        m_rv   = 1'b0;
        m_perr = 1'b0;
      end
    end
  endtask

  // Drive one cycle, advance the model with the same inputs, sample at +1.
  task automatic cycle(input logic r, c, w, input logic [3:0] wa,
                       input logic [7:0] d, input logic inj,
                       input logic rd, input logic [3:0] ra);
    rst = r; clr = c; we = w; write_address = wa; data_in = d;
    inj_par = inj; re = rd; read_address = ra;
    @(posedge clk);
    model_step(r, c, w, wa, d, inj, rd, ra);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic check(input string name, input logic [7:0] edo,
                       input logic erv, edone, eperr);
    checks++;
    if ({data_out, rd_valid, init_done, parity_err} !== {edo, erv, edone, eperr}) begin
      errors++;
      $display("FAIL %s: got do=%02h rv=%0b done=%0b perr=%0b, need do=%02h rv=%0b done=%0b perr=%0b",
               name, data_out, rd_valid, init_done, parity_err, edo, erv, edone, eperr);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic       w;
    logic [3:0] wa;
    logic [7:0] d;
    logic       inj;
    logic       rd;
    logic [3:0] ra;
    logic [7:0] edo;
    logic       erv;
    logic       eperr;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int cnt;
    bit seen_rv;
    logic [7:0] hold;

    vecs[0]  = '{"wr0_A1",    1, 4'd0, 8'hA1, 0, 0, 4'd0, 8'h00, 0, 0};
    vecs[1]  = '{"wr1_B2",    1, 4'd1, 8'hB2, 0, 0, 4'd0, 8'h00, 0, 0};
    vecs[2]  = '{"wr2_C3",    1, 4'd2, 8'hC3, 0, 0, 4'd0, 8'h00, 0, 0};
    vecs[3]  = '{"rd0",       0, 4'd0, 8'h00, 0, 1, 4'd0, 8'hA1, 1, 0};
    vecs[4]  = '{"rd1",       0, 4'd0, 8'h00, 0, 1, 4'd1, 8'hB2, 1, 0};
    vecs[5]  = '{"rd2",       0, 4'd0, 8'h00, 0, 1, 4'd2, 8'hC3, 1, 0};
    vecs[6]  = '{"hold",      0, 4'd0, 8'h00, 0, 0, 4'd0, 8'hC3, 0, 0};
    vecs[7]  = '{"rd5_unwr",  0, 4'd0, 8'h00, 0, 1, 4'd5, 8'h00, 1, 0};
    vecs[8]  = '{"bypass3",   1, 4'd3, 8'h5A, 0, 1, 4'd3, 8'h5A, 1, 0};
    vecs[9]  = '{"rd3",       0, 4'd0, 8'h00, 0, 1, 4'd3, 8'h5A, 1, 0};
    vecs[10] = '{"wr4_inj",   1, 4'd4, 8'h0F, 1, 0, 4'd0, 8'h5A, 0, 0};
    vecs[11] = '{"rd4_bad",   0, 4'd0, 8'h00, 0, 1, 4'd4, 8'h0F, 1, PAR_EN};
    vecs[12] = '{"wr4_ok",    1, 4'd4, 8'h0F, 0, 0, 4'd0, 8'h0F, 0, 0};
    vecs[13] = '{"rd4_ok",    0, 4'd0, 8'h00, 0, 1, 4'd4, 8'h0F, 1, 0};
    vecs[14] = '{"byp6_inj",  1, 4'd6, 8'h07, 1, 1, 4'd6, 8'h07, 1, PAR_EN};
    vecs[15] = '{"wr7_rd8",   1, 4'd7, 8'h33, 0, 1, 4'd8, 8'h00, 1, 0};
    vecs[16] = '{"rd7",       0, 4'd0, 8'h00, 0, 1, 4'd7, 8'h33, 1, 0};

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b1, 4'h2, 8'hEE, 1'b0, 1'b1, 4'h2);
    check("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Sweep length after reset release, with re held high throughout.
    cnt = 0;
    seen_rv = 1'b0;
    while (!init_done && cnt < 40) begin
      cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h1);
      cnt++;
      if (!init_done && rd_valid) seen_rv = 1'b1;
    end
    checks++;
    if (cnt != DEPTH || !init_done) begin
      errors++;
      $display("FAIL sweep_len: got %0d edges (done=%0b), need %0d", cnt, init_done, DEPTH);
    end
    checks++;
    if (seen_rv) begin
      errors++;
      $display("FAIL sweep_rv: got rd_valid=1 during sweep, need 0");
    end
    idle();
    $display("vec sweep_done edges=%0d do=%02h rv=%0b", cnt, data_out, rd_valid);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b0, vecs[i].w, vecs[i].wa, vecs[i].d, vecs[i].inj,
            vecs[i].rd, vecs[i].ra);
      $display("vec %s do=%02h rv=%0b perr=%0b", vecs[i].name, data_out, rd_valid, parity_err);
      check(vecs[i].name, vecs[i].edo, vecs[i].erv, 1'b1, vecs[i].eperr);
    end

    // Clear pulse: same-cycle read dropped, then DEPTH deaf edges.
    hold = data_out;
    cycle(1'b0, 1'b1, 1'b1, 4'h0, 8'hFF, 1'b0, 1'b1, 4'h0);
    check("clr_edge", hold, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'h0, 8'hFF, 1'b0, 1'b1, 4'h0);
      if (k == DEPTH - 1 || k == DEPTH)
        check($sformatf("clr_win%0d", k), hold, 1'b0, (k == DEPTH), 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0);
    check("clr_rd0", 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h1);
    check("clr_rd1", 8'h00, 1'b1, 1'b1, 1'b0);

    // clr during a sweep restarts it: DEPTH edges from the second clr.
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) idle();
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < DEPTH - 1; k++) idle();
    check("restart_pre", 8'h00, 1'b0, 1'b0, 1'b0);
    idle();
    check("restart_done", 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized phase against the model.
    for (int n = 0; n < 1500; n++) begin
      logic r, c, w, inj, rd;
      logic [3:0] wa, ra;
      logic [7:0] d;
      r   = ($urandom_range(0, 299) == 0);
      c   = ($urandom_range(0, 79) == 0);
      w   = $urandom_range(0, 1);
      rd  = $urandom_range(0, 1);
      inj = ($urandom_range(0, 3) == 0);
      wa  = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      d   = 8'($urandom);
      cycle(r, c, w, wa, d, inj, rd, ra);
      if (n % 100 == 0)
        $display("rnd %0d we=%0b wa=%0h re=%0b ra=%0h do=%02h rv=%0b", n, w, wa, rd, ra, data_out, rd_valid);
      check($sformatf("rnd%0d", n), m_do, m_rv, m_done, m_perr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
